// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: move-controller FSM encoding, spawn coordinates,
// move request ids and board dimensions.
package tetris_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned BOARD_W = 20;
  localparam int unsigned BOARD_H = 20;
  localparam int unsigned SPAWN_X = 9;
  localparam int unsigned SPAWN_Y = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUERY,
    ST_WAIT,
    ST_DECIDE,
    ST_LOCK,
    ST_SPAWN_Q,
    ST_SPAWN_W,
    ST_OVER
  } state_t;

  // Request ids double as bit positions in the pending-flag vector.
  typedef enum logic [2:0] {
    REQ_ROT   = 3'd0,
    REQ_LEFT  = 3'd1,
    REQ_RIGHT = 3'd2,
    REQ_DOWN  = 3'd3,
    REQ_GRAV  = 3'd4
  } req_t;

  localparam int unsigned NUM_REQ = 5;

endpackage

// File: rtl/block_move_ctrl_gravity_timer.sv
// gravity_timer: free-running 0..DROP_TICKS-1 counter; o_tick is high for the
// cycle in which it wraps.
//  clk, rst : clock, async active-high reset
//  i_en     : count enable
//  i_clr    : synchronous clear to 0 (wins over counting, suppresses tick)
//  o_tick   : one-cycle wrap pulse
module gravity_timer #(
  parameter int unsigned DROP_TICKS = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [31:0] LAST = 32'(DROP_TICKS - 1);

  logic [31:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_cnt <= '0;
    else if (i_clr)      r_cnt <= '0;
    else if (i_en)       r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 32'd1;
  end

  assign o_tick = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/block_move_ctrl.sv
// block_move_ctrl: arbitrates player moves and gravity, forms one candidate
// placement, asks the collision checker about it and then commits (refresh)
// or locks the piece and respawns. Flags game over on a colliding spawn.
//  clk, rst                     : clock, async active-high reset
//  btn_left/right/rot/down      : one-cycle request pulses
//  cur_x/cur_y/cur_rot          : committed placement from block_pos
//  collide                      : checker result, CHK_LAT cycles after query
//  cand_x/cand_y/cand_rot       : candidate placement to block_pos / checker
//  query/refresh/respawn/lock   : one-cycle control pulses
//  game_over                    : sticky until rst
module block_move_ctrl #(
  parameter int unsigned DROP_TICKS = 50_000_000,
  parameter int unsigned SPAWN_X    = tetris_pkg::SPAWN_X,
  parameter int unsigned SPAWN_Y    = tetris_pkg::SPAWN_Y,
  parameter int          CHK_LAT    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rot,
  input  logic       btn_down,
  input  logic [9:0] cur_x,
  input  logic [9:0] cur_y,
  input  logic [9:0] cur_rot,
  input  logic       collide,
  output logic [9:0] cand_x,
  output logic [9:0] cand_y,
  output logic [9:0] cand_rot,
  output logic       query,
  output logic       refresh,
  output logic       respawn,
  output logic       lock,
  output logic       game_over
);
  import tetris_pkg::*;

  // WAIT covers the CHK_LAT-1 cycles between QUERY and DECIDE; SPAWN_W
  // covers all CHK_LAT cycles after the spawn query.
  localparam logic [1:0] WAIT_LAST = 2'(CHK_LAT >= 2 ? CHK_LAT - 2 : 0);
  localparam logic [1:0] SPWN_LAST = 2'(CHK_LAT - 1);

  state_t             r_state, w_state_nxt;
  req_t               r_req, w_req_nxt;
  logic [NUM_REQ-1:0] r_pend, w_pend_nxt, w_pend_eff, w_new;
  logic [9:0]         r_cand_x, r_cand_y, w_cand_x, w_cand_y;
  logic [1:0]         r_cand_rot, w_cand_rot;
  logic [1:0]         r_wcnt, w_wcnt_nxt;
  logic               w_tick, w_grav_en, w_grav_clr;
  logic               w_unused;

  assign w_unused = ^cur_rot[9:2];

  gravity_timer #(.DROP_TICKS(DROP_TICKS)) u_grav (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_grav_en),
    .i_clr  (w_grav_clr),
    .o_tick (w_tick)
  );

  assign w_grav_en = (r_state != ST_OVER);

  // Same-cycle arrivals are visible to IDLE so a pulse can be served at once.
  assign w_new      = {w_tick, btn_down, btn_right, btn_left, btn_rot};
  assign w_pend_eff = r_pend | w_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_req      <= REQ_ROT;
      r_pend     <= '0;
      r_cand_x   <= '0;
      r_cand_y   <= '0;
      r_cand_rot <= '0;
      r_wcnt     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_pend     <= w_pend_nxt;
      r_cand_x   <= w_cand_x;
      r_cand_y   <= w_cand_y;
      r_cand_rot <= w_cand_rot;
      r_wcnt     <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_pend_nxt  = w_pend_eff;
    w_cand_x    = r_cand_x;
    w_cand_y    = r_cand_y;
    w_cand_rot  = r_cand_rot;
    w_wcnt_nxt  = 2'd0;
    w_grav_clr  = 1'b0;
    query       = 1'b0;
    refresh     = 1'b0;
    respawn     = 1'b0;
    lock        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pend_eff[REQ_ROT]) begin
          w_pend_nxt[REQ_ROT] = 1'b0;
          w_req_nxt   = REQ_ROT;
          w_cand_x    = cur_x;
          w_cand_y    = cur_y;
          w_cand_rot  = cur_rot[1:0] + 2'd1;
          w_state_nxt = ST_QUERY;
        end else if (w_pend_eff[REQ_LEFT]) begin
          w_pend_nxt[REQ_LEFT] = 1'b0;
          // Left at the wall is dropped here; all other bounds are the checker's.
          if (cur_x != 10'd0) begin
            w_req_nxt   = REQ_LEFT;
            w_cand_x    = cur_x - 10'd1;
            w_cand_y    = cur_y;
            w_cand_rot  = cur_rot[1:0];
            w_state_nxt = ST_QUERY;
          end
        end else if (w_pend_eff[REQ_RIGHT]) begin
          w_pend_nxt[REQ_RIGHT] = 1'b0;
          w_req_nxt   = REQ_RIGHT;
          w_cand_x    = cur_x + 10'd1;
          w_cand_y    = cur_y;
          w_cand_rot  = cur_rot[1:0];
          w_state_nxt = ST_QUERY;
        end else if (w_pend_eff[REQ_DOWN] || w_pend_eff[REQ_GRAV]) begin
          if (w_pend_eff[REQ_DOWN]) begin
            w_pend_nxt[REQ_DOWN] = 1'b0;
            w_req_nxt = REQ_DOWN;
          end else begin
            w_pend_nxt[REQ_GRAV] = 1'b0;
            w_req_nxt = REQ_GRAV;
          end
          w_cand_x    = cur_x;
          w_cand_y    = cur_y + 10'd1;
          w_cand_rot  = cur_rot[1:0];
          w_state_nxt = ST_QUERY;
        end
      end
      ST_QUERY: begin
        query       = 1'b1;
        w_state_nxt = (CHK_LAT > 1) ? ST_WAIT : ST_DECIDE;
      end
      ST_WAIT: begin
        w_wcnt_nxt = r_wcnt + 2'd1;
        if (r_wcnt == WAIT_LAST) w_state_nxt = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (!collide) begin
          refresh     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_req == REQ_DOWN || r_req == REQ_GRAV) begin
          w_state_nxt = ST_LOCK;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCK: begin
        lock        = 1'b1;
        respawn     = 1'b1;
        w_grav_clr  = 1'b1;
        w_pend_nxt[REQ_GRAV] = 1'b0;
        w_pend_nxt[REQ_DOWN] = 1'b0;
        w_cand_x    = 10'(SPAWN_X);
        w_cand_y    = 10'(SPAWN_Y);
        w_cand_rot  = 2'd0;
        w_state_nxt = ST_SPAWN_Q;
      end
      ST_SPAWN_Q: begin
        query       = 1'b1;
        w_state_nxt = ST_SPAWN_W;
      end
      ST_SPAWN_W: begin
        w_wcnt_nxt = r_wcnt + 2'd1;
        if (r_wcnt == SPWN_LAST) w_state_nxt = collide ? ST_OVER : ST_IDLE;
      end
      ST_OVER: begin
        w_pend_nxt = r_pend;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign cand_x    = r_cand_x;
  assign cand_y    = r_cand_y;
  assign cand_rot  = {8'b0, r_cand_rot};
  assign game_over = (r_state == ST_OVER);

endmodule
